// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - RV32I/RV64I immediate decode stage with 2-entry skid buffer
// Optional: define IMM_DECODE_ZICSR_EN to decode CSR address / zimm for SYSTEM opcodes.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_DECODE_ZICSR_EN
  localparam logic [2:0] T_Z    = 3'd6;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state;

  logic [31:0]     dec_imm32;
  logic            dec_zext;
  logic [2:0]      dec_type;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_type;
  logic            skid_illegal;
  logic [XLEN-1:0] skid_pc;

  logic in_fire;
  logic out_fire;

  // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    dec_imm32   = '0;
    dec_zext    = 1'b0;
    dec_type    = T_NONE;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      OP_OPIMM, OP_LOAD, OP_JALR: begin
        dec_type  = T_I;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        dec_type  = T_S;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec_type  = T_B;
        dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_type  = T_U;
        dec_imm32 = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_type  = T_J;
        dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_OP, OP_MISC: begin
        dec_type = T_NONE;
      end
      OP_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
        case (in_inst[14:12])
          3'b001, 3'b010, 3'b011: begin
            dec_type  = T_I;
            dec_zext  = 1'b1;
            dec_imm32 = {20'b0, in_inst[31:20]};
          end
          3'b101, 3'b110, 3'b111: begin
            dec_type  = T_Z;
            dec_zext  = 1'b1;
            dec_imm32 = {27'b0, in_inst[19:15]};
          end
          default: dec_type = T_NONE;
        endcase
`else
        dec_type = T_NONE;
`endif
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_imm = dec_zext ? XLEN'(dec_imm32) : XLEN'($signed(dec_imm32));

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      out_imm      <= '0;
      out_type     <= T_NONE;
      out_illegal  <= 1'b0;
      out_pc       <= '0;
      skid_imm     <= '0;
      skid_type    <= T_NONE;
      skid_illegal <= 1'b0;
      skid_pc      <= '0;
      illegal_cnt  <= '0;
    end else begin
      if (out_fire && out_illegal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + 1'b1;
      case (state)
        EMPTY: begin
          if (in_fire) begin
            out_imm     <= dec_imm;
            out_type    <= dec_type;
            out_illegal <= dec_illegal;
            out_pc      <= in_pc;
            state       <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_imm     <= dec_imm;
            out_type    <= dec_type;
            out_illegal <= dec_illegal;
            out_pc      <= in_pc;
          end else if (in_fire) begin
            skid_imm     <= dec_imm;
            skid_type    <= dec_type;
            skid_illegal <= dec_illegal;
            skid_pc      <= in_pc;
            state        <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_imm     <= skid_imm;
            out_type    <= skid_type;
            out_illegal <= skid_illegal;
            out_pc      <= skid_pc;
            state       <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage (XLEN 32 and 64)
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [31:0] pc = 32'h0;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm, r32_out_pc;
  logic [2:0]  r32_out_type;
  logic [15:0] r32_cnt;

  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm, r64_out_pc;
  logic [2:0]  r64_out_type;
  logic [0:0]  r64_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_inst(in_inst), .in_pc(pc), .out_valid(r32_out_valid), .out_ready(out_ready),
    .out_imm(r32_out_imm), .out_type(r32_out_type), .out_illegal(r32_out_illegal),
    .out_pc(r32_out_pc), .illegal_cnt(r32_cnt)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_inst(in_inst), .in_pc({32'h0, pc}), .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_imm(r64_out_imm), .out_type(r64_out_type), .out_illegal(r64_out_illegal),
    .out_pc(r64_out_pc), .illegal_cnt(r64_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] p);
    in_valid = 1'b1;
    in_inst  = inst;
    pc       = p;
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_valid", 64'(r32_out_valid), 64'd0);
    check("rst_ready", 64'(r32_in_ready), 64'd1);
    check("rst_imm",   r64_out_imm, 64'd0);
    check("rst_type",  64'(r32_out_type), 64'd0);
    check("rst_ill",   64'(r32_out_illegal), 64'd0);
    check("rst_pc",    64'(r32_out_pc), 64'd0);
    check("rst_cnt",   64'(r32_cnt), 64'd0);
    rst = 1'b0;

    // streaming with out_ready high
    out_ready = 1'b1;
    offer(32'hFFF00093, 32'h100);
    step();
    check("addi_valid", 64'(r32_out_valid), 64'd1);
    check("addi_imm",   64'(r32_out_imm), 64'hFFFFFFFF);
    check("addi_type",  64'(r32_out_type), 64'd1);
    check("addi_pc",    64'(r32_out_pc), 64'h100);
    check("addi_imm64", r64_out_imm, 64'hFFFFFFFFFFFFFFFF);
    offer(32'hFE112E23, 32'h104);
    step();
    check("sw_imm",   64'(r32_out_imm), 64'hFFFFFFFC);
    check("sw_type",  64'(r32_out_type), 64'd2);
    check("sw_pc",    64'(r32_out_pc), 64'h104);
    offer(32'h800000EF, 32'h108);
    step();
    check("jal_imm",   64'(r32_out_imm), 64'hFFF00000);
    check("jal_type",  64'(r32_out_type), 64'd5);
    check("jal_imm64", r64_out_imm, 64'hFFFFFFFFFFF00000);
    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(r32_out_valid), 64'd0);

    // U and B formats, both widths
    offer(32'h80000037, 32'h200);
    step();
    check("lui_imm64",  r64_out_imm, 64'hFFFFFFFF80000000);
    check("lui_type64", 64'(r64_out_type), 64'd4);
    check("lui_imm32",  64'(r32_out_imm), 64'h80000000);
    offer(32'hFE000EE3, 32'h204);
    step();
    check("beq_imm64",  r64_out_imm, 64'hFFFFFFFFFFFFFFFC);
    check("beq_type64", 64'(r64_out_type), 64'd3);
    check("beq_pc64",   r64_out_pc, 64'h204);
    in_valid = 1'b0;
    step();

    // back-pressure: three offers, only two captured
    out_ready = 1'b0;
    offer(32'h00500093, 32'h300);
    step();
    check("bp1_ready", 64'(r32_in_ready), 64'd1);
    check("bp1_imm",   64'(r32_out_imm), 64'd5);
    offer(32'h00700093, 32'h304);
    step();
    check("bp2_ready", 64'(r32_in_ready), 64'd0);
    check("bp2_imm",   64'(r32_out_imm), 64'd5);
    offer(32'h00900093, 32'h308);
    step();
    check("bp3_ready", 64'(r32_in_ready), 64'd0);
    check("bp3_imm",   64'(r32_out_imm), 64'd5);
    check("bp3_pc",    64'(r32_out_pc), 64'h300);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_w2_valid", 64'(r32_out_valid), 64'd1);
    check("bp_w2_imm",   64'(r32_out_imm), 64'd7);
    check("bp_w2_pc",    64'(r32_out_pc), 64'h304);
    step();
    check("bp_empty", 64'(r32_out_valid), 64'd0);

    // illegal word twice, counter saturation at CNT_W=1
    offer(32'h00000000, 32'h400);
    step();
    check("ill1_flag", 64'(r64_out_illegal), 64'd1);
    check("ill1_type", 64'(r64_out_type), 64'd0);
    check("ill1_cnt",  64'(r64_cnt), 64'd0);
    offer(32'h00000000, 32'h404);
    step();
    check("ill2_flag", 64'(r64_out_illegal), 64'd1);
    check("ill2_cnt",  64'(r64_cnt), 64'd1);
    offer(32'h00500090, 32'h408);
    step();
    check("ill3_flag",  64'(r32_out_illegal), 64'd1);
    check("ill3_imm",   64'(r32_out_imm), 64'd0);
    in_valid = 1'b0;
    step();
    check("ill_sat64", 64'(r64_cnt), 64'd1);
    check("ill_cnt32", 64'(r32_cnt), 64'd3);

    // csrrwi
    offer(32'h3057D073, 32'h500);
    step();
`ifdef IMM_DECODE_ZICSR_EN
    check("csr_type", 64'(r32_out_type), 64'd6);
    check("csr_imm",  64'(r32_out_imm), 64'd15);
`else
    check("csr_type", 64'(r32_out_type), 64'd0);
    check("csr_imm",  64'(r32_out_imm), 64'd0);
`endif
    check("csr_ill", 64'(r32_out_illegal), 64'd0);
    in_valid = 1'b0;
    step();

    // fill to FULL, then asynchronous reset between edges
    out_ready = 1'b0;
    offer(32'h00100093, 32'h600);
    step();
    offer(32'h00200093, 32'h604);
    step();
    check("pre_rst_full", 64'(r32_in_ready), 64'd0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(r32_out_valid), 64'd0);
    check("arst_ready", 64'(r32_in_ready), 64'd1);
    check("arst_cnt",   64'(r32_cnt), 64'd0);
    check("arst_imm",   64'(r32_out_imm), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    offer(32'hFFF00093, 32'h700);
    step();
    check("post_rst_valid", 64'(r32_out_valid), 64'd1);
    check("post_rst_imm",   64'(r32_out_imm), 64'hFFFFFFFF);
    check("post_rst_pc",    64'(r32_out_pc), 64'h700);
    in_valid = 1'b0;
    step();
    check("post_rst_drop", 64'(r32_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
